// File: rtl/decoder_scan_nx.sv
// Registered N-to-2^N one-hot decoder with two modes: direct select through a
// valid/ready handshake, and an automatic scan that dwells on each output line.
module decoder_scan_nx #(
  parameter int SEL_W      = 2,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic                   sel_valid,
  output logic                   sel_ready,
  output logic [(1<<SEL_W)-1:0]  y,
  output logic [SEL_W-1:0]       idx,
  output logic                   step
);

  localparam int N_OUT = 1 << SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
  localparam logic [N_OUT-1:0] Y_IDLE  = ACTIVE_LOW ? {N_OUT{1'b1}} : {N_OUT{1'b0}};

  logic [SEL_W-1:0] idx_r, idx_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             step_r, step_next_s;
  logic [N_OUT-1:0] y_r, y_next_s;

  // One line active at the chosen index, inverted for active-low boards.
  function automatic logic [N_OUT-1:0] decode(input logic [SEL_W-1:0] code);
    logic [N_OUT-1:0] v;
    v       = {N_OUT{1'b0}};
    v[code] = 1'b1;
    return ACTIVE_LOW ? ~v : v;
  endfunction

  assign sel_ready = en & ~mode;
  assign idx       = idx_r;
  assign step      = step_r;
  assign y         = y_r;

  // Next-state logic for index, dwell counter, step pulse and decoded outputs.
  always_comb begin
    idx_next_s  = idx_r;
    cnt_next_s  = cnt_r;
    step_next_s = 1'b0;
    if (en) begin
      if (mode) begin
        if (cnt_r == CNT_MAX) begin
          cnt_next_s  = {CNT_W{1'b0}};
          idx_next_s  = idx_r + SEL_W'(1);
          step_next_s = 1'b1;
        end else begin
          cnt_next_s  = cnt_r + CNT_W'(1);
        end
      end else begin
        // Counter parked at zero so a later switch to scan dwells a full period.
        cnt_next_s = {CNT_W{1'b0}};
        if (sel_valid) begin
          idx_next_s = sel_in;
        end else begin
          idx_next_s = idx_r;
        end
      end
    end else begin
      idx_next_s = idx_r;
      cnt_next_s = cnt_r;
    end
    y_next_s = en ? decode(idx_next_s) : Y_IDLE;
  end

  // State and output registers; reset blanks the outputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r  <= {SEL_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      step_r <= 1'b0;
      y_r    <= Y_IDLE;
    end else begin
      idx_r  <= idx_next_s;
      cnt_r  <= cnt_next_s;
      step_r <= step_next_s;
      y_r    <= y_next_s;
    end
  end

endmodule

// File: tb/tb_decoder_scan_nx.sv
// Directed bench: a DWELL=3 active-high decoder and a DWELL=1 active-low
// decoder share one stimulus stream.
module tb_decoder_scan_nx;

  logic       clk, rst_n, en, mode, sel_valid;
  logic [1:0] sel_in;
  logic       sel_ready, step, ready_al, step_al;
  logic [3:0] y, y_al;
  logic [1:0] idx, idx_al;
  int checks = 0;
  int errors = 0;

  decoder_scan_nx #(.SEL_W(2), .DWELL(3), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .y(y), .idx(idx), .step(step));

  decoder_scan_nx #(.SEL_W(2), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
    .sel_valid(sel_valid), .sel_ready(ready_al), .y(y_al), .idx(idx_al), .step(step_al));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel_in = 2'd0;
    #12;
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL reset_y: got %b expected %b", y, 4'b0000); end
    checks++; if (idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected %0d", idx, 0); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected %b", step, 1'b0); end
    checks++; if (y_al !== 4'b1111) begin errors++; $display("FAIL reset_y_al: got %b expected %b", y_al, 4'b1111); end
    rst_n = 1'b1;
    tick();
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL en_off_y: got %b expected %b", y, 4'b0000); end
    checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL en_off_ready: got %b expected %b", sel_ready, 1'b0); end
    en = 1'b1;
    tick();
    checks++; if (y !== 4'b0001) begin errors++; $display("FAIL en_on_y: got %b expected %b", y, 4'b0001); end
  endtask

  task automatic test_direct;
    sel_in = 2'd2; sel_valid = 1'b1;
    #1;
    checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL direct_ready: got %b expected %b", sel_ready, 1'b1); end
    tick();
    checks++; if (y !== 4'b0100) begin errors++; $display("FAIL direct_y2: got %b expected %b", y, 4'b0100); end
    checks++; if (idx !== 2'd2) begin errors++; $display("FAIL direct_idx2: got %0d expected %0d", idx, 2); end
    sel_in = 2'd3; sel_valid = 1'b0;
    tick();
    checks++; if (y !== 4'b0100) begin errors++; $display("FAIL direct_hold: got %b expected %b", y, 4'b0100); end
    sel_valid = 1'b1;
    tick();
    checks++; if (y !== 4'b1000) begin errors++; $display("FAIL direct_y3: got %b expected %b", y, 4'b1000); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL direct_step: got %b expected %b", step, 1'b0); end
    sel_in = 2'd0;
    tick();
    checks++; if (y !== 4'b0001) begin errors++; $display("FAIL direct_y0: got %b expected %b", y, 4'b0001); end
  endtask

  task automatic test_scan_wrap;
    logic [3:0] exp_y [12];
    logic       exp_s [12];
    exp_y = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100,
              4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
    exp_s = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    mode = 1'b1; sel_valid = 1'b1; sel_in = 2'd3;
    #1;
    checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL scan_ready: got %b expected %b", sel_ready, 1'b0); end
    for (int e = 0; e < 12; e++) begin
      tick();
      checks++; if (y !== exp_y[e]) begin errors++; $display("FAIL scan_y[%0d]: got %b expected %b", e, y, exp_y[e]); end
      checks++; if (step !== exp_s[e]) begin errors++; $display("FAIL scan_step[%0d]: got %b expected %b", e, step, exp_s[e]); end
    end
    sel_valid = 1'b0;
  endtask

  task automatic test_dwell1_active_low;
    logic [3:0] exp_y [5];
    exp_y = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    pulse_reset();
    checks++; if (y_al !== 4'b1111) begin errors++; $display("FAIL al_reset_y: got %b expected %b", y_al, 4'b1111); end
    for (int e = 0; e < 5; e++) begin
      tick();
      checks++; if (y_al !== exp_y[e]) begin errors++; $display("FAIL al_y[%0d]: got %b expected %b", e, y_al, exp_y[e]); end
      checks++; if (step_al !== 1'b1) begin errors++; $display("FAIL al_step[%0d]: got %b expected %b", e, step_al, 1'b1); end
    end
  endtask

  task automatic test_enable_freeze;
    pulse_reset();
    for (int e = 0; e < 7; e++) tick();
    checks++; if (idx !== 2'd2) begin errors++; $display("FAIL freeze_pre_idx: got %0d expected %0d", idx, 2); end
    en = 1'b0;
    for (int e = 0; e < 2; e++) begin
      tick();
      checks++; if (y !== 4'b0000) begin errors++; $display("FAIL freeze_y[%0d]: got %b expected %b", e, y, 4'b0000); end
      checks++; if (step !== 1'b0) begin errors++; $display("FAIL freeze_step[%0d]: got %b expected %b", e, step, 1'b0); end
      checks++; if (idx !== 2'd2) begin errors++; $display("FAIL freeze_idx[%0d]: got %0d expected %0d", e, idx, 2); end
    end
    en = 1'b1;
    tick();
    checks++; if (y !== 4'b0100) begin errors++; $display("FAIL resume_y: got %b expected %b", y, 4'b0100); end
    tick();
    checks++; if (y !== 4'b1000) begin errors++; $display("FAIL resume_adv_y: got %b expected %b", y, 4'b1000); end
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL resume_adv_step: got %b expected %b", step, 1'b1); end
  endtask

  task automatic test_async_reset;
    rst_n = 1'b0;
    #2;
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL async_y: got %b expected %b", y, 4'b0000); end
    checks++; if (idx !== 2'd0) begin errors++; $display("FAIL async_idx: got %0d expected %0d", idx, 0); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL async_step: got %b expected %b", step, 1'b0); end
    rst_n = 1'b1;
    mode = 1'b0; sel_in = 2'd1; sel_valid = 1'b1;
    #1;
    checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL switch_ready: got %b expected %b", sel_ready, 1'b1); end
    tick();
    checks++; if (y !== 4'b0010) begin errors++; $display("FAIL switch_y: got %b expected %b", y, 4'b0010); end
    sel_valid = 1'b0;
  endtask

  task automatic test_scan_to_direct;
    mode = 1'b1;
    for (int e = 0; e < 3; e++) tick();
    checks++; if (y !== 4'b0100) begin errors++; $display("FAIL s2d_scan_y: got %b expected %b", y, 4'b0100); end
    mode = 1'b0;
    tick();
    checks++; if (y !== 4'b0100) begin errors++; $display("FAIL s2d_hold_y: got %b expected %b", y, 4'b0100); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL s2d_step: got %b expected %b", step, 1'b0); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_wrap();
    test_dwell1_active_low();
    test_enable_freeze();
    test_async_reset();
    test_scan_to_direct();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
